// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch target buffer.
// Index/tag extraction and saturating counter arithmetic.
package btb_pkg;

   typedef enum logic {IDLE, CLEAR} state_e;

   localparam int MAX_W  = 64;
   localparam int CMAX_W = 8;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic logic [MAX_W-1:0] idx_of(
      input logic [MAX_W-1:0] pc,
      input int               idx_w
   );
      return (pc >> 2) & ((MAX_W'(1) << idx_w) - MAX_W'(1));
   endfunction

   function automatic logic [MAX_W-1:0] tag_of(
      input logic [MAX_W-1:0] pc,
      input int               idx_w
   );
      return pc >> (idx_w + 2);
   endfunction

   function automatic logic [CMAX_W-1:0] ctr_inc(
      input logic [CMAX_W-1:0] c,
      input logic [CMAX_W-1:0] mx
   );
      return (c >= mx) ? c : c + CMAX_W'(1);
   endfunction

   function automatic logic [CMAX_W-1:0] ctr_dec(
      input logic [CMAX_W-1:0] c
   );
      return (c == '0) ? c : c - CMAX_W'(1);
   endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// Saturating up/down direction counter with load-max and load-value.
// One instance per table entry.
module btb_sat_counter
   import btb_pkg::*;
#(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc_i,
   input  logic         dec_i,
   input  logic         ld_max_i,
   input  logic         ld_i,
   input  logic [W-1:0] ld_val_i,
   output logic [W-1:0] cnt_o
);

   localparam logic [CMAX_W-1:0] MAXV = CMAX_W'((1 << W) - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      unique case (1'b1)
         ld_max_i: cnt_d = W'(MAXV);
         ld_i:     cnt_d = ld_val_i;
         inc_i:    cnt_d = W'(ctr_inc(CMAX_W'(cnt_q), MAXV));
         dec_i:    cnt_d = W'(ctr_dec(CMAX_W'(cnt_q)));
         default:  cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with per-entry direction counters and invalidate sweep.
// Optional perf counters via `define BTB_PERF_CNT_EN.
module branch_target_buffer
   import btb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int ENTRIES = 16,
   parameter int CTR_W   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] lk_pc,
   output logic              lk_hit,
   output logic              lk_taken,
   output logic [ADDR_W-1:0] lk_target,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_uncond,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              flush_req,
   output logic              busy
`ifdef BTB_PERF_CNT_EN
  ,output logic [31:0]       perf_lookups,
   output logic [31:0]       perf_hits,
   output logic [31:0]       perf_mispred
`endif
);

   localparam int IDX_W = clog2(ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;
   localparam logic [CTR_W-1:0] WT = CTR_W'(1 << (CTR_W - 1));

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   sidx_q, sidx_d;
   logic [ENTRIES-1:0] valid_q, valid_d;

   logic [TAG_W-1:0]   tag_q [ENTRIES];
   logic [ADDR_W-1:0]  tgt_q [ENTRIES];
   logic [CTR_W-1:0]   ctr   [ENTRIES];

   logic [IDX_W-1:0]   li, ui;
   logic [TAG_W-1:0]   lt, ut;
   logic               l_hit, u_hit, u_tk, acc, wr, alloc;

   logic [ENTRIES-1:0] inc_v, dec_v, ldm_v, ld_v;

   assign li = IDX_W'(idx_of(MAX_W'(lk_pc), IDX_W));
   assign lt = TAG_W'(tag_of(MAX_W'(lk_pc), IDX_W));
   assign ui = IDX_W'(idx_of(MAX_W'(upd_pc), IDX_W));
   assign ut = TAG_W'(tag_of(MAX_W'(upd_pc), IDX_W));

   assign busy      = (state_q == CLEAR);
   assign l_hit     = valid_q[li] && (tag_q[li] == lt);
   assign lk_hit    = l_hit && !busy;
   assign lk_taken  = lk_hit && (ctr[li] >= WT);
   assign lk_target = lk_hit ? tgt_q[li] : '0;

   assign acc   = upd_valid && (state_q == IDLE);
   assign u_hit = valid_q[ui] && (tag_q[ui] == ut);
   assign u_tk  = upd_uncond || upd_taken;
   assign wr    = acc && u_tk;
   assign alloc = wr && !u_hit;

   always_comb begin
      inc_v = '0;
      dec_v = '0;
      ldm_v = '0;
      ld_v  = '0;
      if (acc) begin
         if (upd_uncond)     ldm_v[ui] = 1'b1;
         else if (!u_hit)    ld_v[ui]  = alloc;
         else if (upd_taken) inc_v[ui] = 1'b1;
         else                dec_v[ui] = 1'b1;
      end
   end

   for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
      btb_sat_counter #(.W(CTR_W)) u_ctr (
         .clk      (clk),
         .rst      (rst),
         .inc_i    (inc_v[g]),
         .dec_i    (dec_v[g]),
         .ld_max_i (ldm_v[g]),
         .ld_i     (ld_v[g]),
         .ld_val_i (WT),
         .cnt_o    (ctr[g])
      );
   end

   always_comb begin
      state_d = state_q;
      sidx_d  = sidx_q;
      valid_d = valid_q;
      unique case (state_q)
         IDLE: begin
            if (alloc)     valid_d[ui] = 1'b1;
            if (flush_req) state_d     = CLEAR;
         end
         CLEAR: begin
            valid_d[sidx_q] = 1'b0;
            sidx_d          = sidx_q + IDX_W'(1);
            if (sidx_q == IDX_W'(ENTRIES - 1)) begin
               sidx_d  = '0;
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         sidx_q  <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         sidx_q  <= sidx_d;
         valid_q <= valid_d;
      end
   end

   // Tag/target storage is qualified by valid, so no reset needed.
   always_ff @(posedge clk) begin
      if (wr) begin
         tag_q[ui] <= ut;
         tgt_q[ui] <= upd_target;
      end
   end

`ifdef BTB_PERF_CNT_EN
   logic p_pred, p_mis;

   assign p_pred = u_hit && (ctr[ui] >= WT);
   assign p_mis  = acc && ((p_pred != u_tk) ||
                   (p_pred && (tgt_q[ui] != upd_target)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_lookups <= '0;
         perf_hits    <= '0;
         perf_mispred <= '0;
      end else begin
         if (!busy)  perf_lookups <= perf_lookups + 32'd1;
         if (lk_hit) perf_hits    <= perf_hits + 32'd1;
         if (p_mis)  perf_mispred <= perf_mispred + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Randomized bench for branch_target_buffer against a table-level model,
// plus directed scenarios with literal expectations.
module tb_branch_target_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] lk_pc;
   logic        lk_hit, lk_taken;
   logic [31:0] lk_target;
   logic        upd_valid, upd_uncond, upd_taken;
   logic [31:0] upd_pc, upd_target;
   logic        flush_req;
   logic        busy;

   int vec = 0;
   int mis = 0;

   bit          m_v   [16];
   logic [31:0] m_tag [16];
   logic [31:0] m_tgt [16];
   int          m_ctr [16];
   int          m_left;

   always #5 clk = ~clk;

   branch_target_buffer dut (
      .clk        (clk),
      .rst        (rst),
      .lk_pc      (lk_pc),
      .lk_hit     (lk_hit),
      .lk_taken   (lk_taken),
      .lk_target  (lk_target),
      .upd_valid  (upd_valid),
      .upd_pc     (upd_pc),
      .upd_uncond (upd_uncond),
      .upd_taken  (upd_taken),
      .upd_target (upd_target),
      .flush_req  (flush_req),
      .busy       (busy)
   );

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         mis++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic void m_reset();
      for (int i = 0; i < 16; i++) begin
         m_v[i]   = 0;
         m_ctr[i] = 0;
      end
      m_left = 0;
   endfunction

   task automatic check_model();
      int   i;
      bit   h;
      i = int'((lk_pc >> 2) % 16);
      h = (m_left == 0) && m_v[i] && (m_tag[i] == (lk_pc >> 6));
      chk("busy",   {31'd0, busy},     {31'd0, m_left > 0});
      chk("hit",    {31'd0, lk_hit},   {31'd0, h});
      chk("taken",  {31'd0, lk_taken}, {31'd0, h && m_ctr[i] >= 2});
      chk("target", lk_target,         h ? m_tgt[i] : 32'd0);
   endtask

   function automatic void m_clock();
      int i;
      bit h;
      if (m_left > 0) begin
         m_v[16 - m_left] = 0;
         m_left--;
      end else begin
         if (upd_valid) begin
            i = int'((upd_pc >> 2) % 16);
            h = m_v[i] && (m_tag[i] == (upd_pc >> 6));
            if (h) begin
               if (upd_uncond) begin
                  m_ctr[i] = 3;
                  m_tgt[i] = upd_target;
               end else if (upd_taken) begin
                  if (m_ctr[i] < 3) m_ctr[i]++;
                  m_tgt[i] = upd_target;
               end else if (m_ctr[i] > 0) begin
                  m_ctr[i]--;
               end
            end else if (upd_uncond || upd_taken) begin
               m_v[i]   = 1;
               m_tag[i] = upd_pc >> 6;
               m_tgt[i] = upd_target;
               m_ctr[i] = upd_uncond ? 3 : 2;
            end
         end
         if (flush_req) m_left = 16;
      end
   endfunction

   // One clock: check outputs, advance DUT and model, idle inputs.
   task automatic cyc();
      #1 check_model();
      @(posedge clk);
      m_clock();
      @(negedge clk);
      upd_valid = 1'b0;
      flush_req = 1'b0;
   endtask

   task automatic upd(logic [31:0] pc, bit unc, bit tk, logic [31:0] tg);
      upd_valid  = 1'b1;
      upd_pc     = pc;
      upd_uncond = unc;
      upd_taken  = tk;
      upd_target = tg;
      cyc();
   endtask

   task automatic look(string nm, logic [31:0] pc,
                       bit eh, bit et, logic [31:0] etg);
      lk_pc = pc;
      #1;
      chk({nm, ".hit"},    {31'd0, lk_hit},   {31'd0, eh});
      chk({nm, ".taken"},  {31'd0, lk_taken}, {31'd0, et});
      chk({nm, ".target"}, lk_target,         etg);
      check_model();
   endtask

   initial begin
      rst        = 1'b0;
      lk_pc      = 32'h40;
      upd_valid  = 1'b0;
      upd_pc     = '0;
      upd_uncond = 1'b0;
      upd_taken  = 1'b0;
      upd_target = '0;
      flush_req  = 1'b0;
      m_reset();
      repeat (3) @(negedge clk);
      #1;
      chk("rst.busy", {31'd0, busy}, 32'd0);
      look("rst", 32'h40, 0, 0, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      upd(32'h40, 0, 1, 32'h80);
      look("alloc", 32'h40, 1, 1, 32'h80);
      upd(32'h40, 0, 0, 32'h0);
      upd(32'h40, 0, 0, 32'h0);
      look("ctr0", 32'h40, 1, 0, 32'h80);
      for (int k = 0; k < 4; k++) upd(32'h40, 0, 1, 32'h84);
      look("sat3", 32'h43, 1, 1, 32'h84);
      upd(32'h40, 0, 0, 32'h0);
      look("ctr2", 32'h40, 1, 1, 32'h84);
      upd(32'h40, 0, 0, 32'h0);
      look("ctr1", 32'h40, 1, 0, 32'h84);

      upd(32'h80, 0, 1, 32'h123);
      look("alias.old", 32'h40, 0, 0, 32'h0);
      look("alias.new", 32'h80, 1, 1, 32'h123);
      upd(32'h100, 0, 0, 32'h999);
      look("nt.noalloc", 32'h100, 0, 0, 32'h0);
      upd(32'h100, 1, 0, 32'h200);
      look("unc", 32'h100, 1, 1, 32'h200);
      upd(32'h100, 0, 0, 32'h0);
      look("unc.ctr2", 32'h100, 1, 1, 32'h200);

      for (int k = 0; k < 16; k++) upd(32'h1000 + k * 4, 1, 0, 32'h5000 + k);
      look("full", 32'h103c, 1, 1, 32'h500f);
      flush_req = 1'b1;
      cyc();
      for (int k = 0; k < 16; k++) begin
         chk("sweep.busy", {31'd0, busy}, 32'd1);
         upd_valid  = 1'b1;
         upd_pc     = 32'h2000 + k * 4;
         upd_uncond = 1'b1;
         upd_target = 32'h77;
         flush_req  = 1'b1;
         lk_pc      = 32'h1000 + k * 4;
         cyc();
      end
      chk("sweep.done", {31'd0, busy}, 32'd0);
      for (int k = 0; k < 16; k++) begin
         look("cleared", 32'h1000 + k * 4, 0, 0, 32'h0);
         look("dropped", 32'h2000 + k * 4, 0, 0, 32'h0);
      end

      // Update and flush in the same idle cycle.
      upd_valid  = 1'b1;
      upd_pc     = 32'h44;
      upd_uncond = 1'b1;
      upd_target = 32'hAA;
      flush_req  = 1'b1;
      lk_pc      = 32'h44;
      cyc();
      chk("upd+flush.busy", {31'd0, busy}, 32'd1);
      repeat (16) cyc();

      for (int n = 0; n < 3000; n++) begin
         lk_pc      = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2)
                      | $urandom_range(0, 3);
         upd_valid  = ($urandom_range(0, 1) == 1);
         upd_pc     = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2)
                      | $urandom_range(0, 3);
         upd_uncond = ($urandom_range(0, 5) == 0);
         upd_taken  = ($urandom_range(0, 1) == 1);
         upd_target = $urandom;
         flush_req  = ($urandom_range(0, 63) == 0);
         cyc();
      end

      for (int k = 0; k < 16; k++) upd(32'h3000 + k * 4, 0, 1, 32'h10 + k);
      flush_req = 1'b1;
      cyc();
      repeat (5) cyc();
      #2 rst = 1'b0;
      m_reset();
      #1;
      chk("abort.busy", {31'd0, busy}, 32'd0);
      look("abort", 32'h3030, 0, 0, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      look("after", 32'h3030, 0, 0, 32'h0);
      upd(32'h3030, 0, 1, 32'h55);
      look("after.alloc", 32'h3030, 1, 1, 32'h55);

      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end

endmodule
